dcpu16_ictl: RTL and testbench
==============================

DCPU16_ICTL -- requirements
Module: dcpu16_ictl

Interface
REQ-001 The block SHALL have reset rst, synchronous, active-high, and clock clk.
REQ-002 The ports SHALL be, in order:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- ena  input  1  pipe advance from the memory bus (0 = stall)
- f_dti  input  16  fetched instruction word, valid when pha==2 and ena==1
- regA  input  16  resolved operand A of the current instruction
- regB  input  16  resolved operand B of the current instruction
- pha  output  2  instruction phase counter
- ireg  output  16  instruction register {b[5:0], a[5:0], o[3:0]}
- opc  output  4  ireg[3:0]
- CC  output  1  condition-true flag; 0 = current instruction skipped
- bra  output  1  current instruction writes PC
- rwe  output  1  register-file writeback enable for operand A
- ifx  output  1  current instruction is IFE/IFN/IFG/IFB

Function
REQ-003 pha SHALL advance 0->1->2->3->0 by one on each clk edge with ena=1, and SHALL hold while ena=0.
REQ-004 On an edge with ena=1 and pha==2, ireg SHALL load f_dti; at all other times ireg SHALL hold.
REQ-005 opc SHALL equal ireg[3:0] combinationally.
REQ-006 ifx SHALL be 1 iff opc is 0xC, 0xD, 0xE or 0xF.
REQ-007 The IF condition SHALL be computed combinationally from regA and regB:
- IFE (0xC): regA == regB
- IFN (0xD): regA != regB
- IFG (0xE): regA > regB, unsigned 16-bit
- IFB (0xF): (regA & regB) != 0
REQ-008 CC SHALL update only on an edge with ena=1 and pha==2, the same edge that loads ireg, as follows:
- If the outgoing ireg is an IF, CC==1, and its condition is false: CC<=0.
- Otherwise: CC<=1.
REQ-009 CC==0 SHALL persist for exactly the one following instruction (pha 3,0,1,2); single-instruction skip.
REQ-010 An IF that is itself skipped (CC==0) SHALL NOT be evaluated; CC SHALL return to 1 at the next ireg load.
REQ-011 Next-word fetches of a skipped instruction SHALL proceed normally; only its writes are suppressed via CC.
REQ-012 rwe SHALL be 1 iff all of the following hold:
- CC==1
- opc is in 0x1..0xB
- a-field ireg[9:4] is in 0x00..0x07 (register direct)
REQ-013 rwe SHALL be 0 for:
- IF opcodes
- opc==0 (non-basic)
- any a-field other than register direct; memory, SP, PC, O and literal writes are owned by the memory bus and ALU.
REQ-014 bra SHALL be 1 iff CC==1 and either of the following holds:
- opc in 0x1..0xB and a-field==0x1C (PC target)
- opc==0 and ireg[9:4]==0x01 (JSR)
REQ-015 Non-basic instructions other than JSR, including 0x0000, SHALL behave as NOP: rwe=0, bra=0, ifx=0.
REQ-016 rwe, bra and ifx SHALL be combinational from ireg and CC, with no added latency.
REQ-017 A stall (ena=0) at any phase SHALL freeze pha, ireg and CC with no loss of state.

Reset
REQ-018 On rst=1 at a clk edge, regardless of ena, the block SHALL set pha=0, ireg=16'h0000 and CC=1.
REQ-019 Reset asserted mid-instruction SHALL abandon any pending skip; the first instruction after reset SHALL execute unconditionally.
REQ-020 After reset, the first ireg load SHALL occur on the third ena=1 edge, when pha==2.

Verification
REQ-021 The bench SHALL cover:
- Reset, ena=1 continuously, f_dti=0x7C01 at pha 2 -> pha sequence 0,1,2,3,0; ireg=0x7C01 after third edge; opc=1; rwe=1; bra=0.
- IFE with regA=0x0005, regB=0x0005, then next ireg 0x0401 -> CC=1 for the following instruction; rwe=1.
- IFN with regA=regB=0x1234 -> CC=0 for the next instruction; rwe=0; bra=0; CC=1 again after the second ireg load.
- IFG with regA=0x8000, regB=0x7FFF -> CC=1 (unsigned); swapped values -> CC=0.
- Skipped IFB (CC=0, (regA&regB)==0) followed by a SET PC instruction 0x7DC1 -> IFB not evaluated; SET PC executes with CC=1 and bra=1.
- ena=0 held 5 cycles at pha 2 with f_dti changing -> pha, ireg, CC unchanged; rst mid-skip -> CC=1, pha=0, ireg=0.

Source files
------------

// File: rtl/dcpu16_ictl.sv
// DCPU-16 instruction control: phase counter, instruction register,
// IF-skip condition flag and the decoded writeback/branch strobes.
module dcpu16_ictl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [15:0] f_dti,
   input  logic [15:0] regA,
   input  logic [15:0] regB,
   output logic [1:0]  pha,
   output logic [15:0] ireg,
   output logic [3:0]  opc,
   output logic        CC,
   output logic        bra,
   output logic        rwe,
   output logic        ifx
);

   logic       cond;
   logic       basic;
   logic [5:0] a_fld;

   assign opc   = ireg[3:0];
   assign a_fld = ireg[9:4];
   assign basic = (opc != 4'h0) && (opc <= 4'hB);
   assign ifx   = (opc[3:2] == 2'b11);

   // IF condition of the instruction currently held in ireg
   always_comb begin
      cond = 1'b0;
      case (opc)
         4'hC:    cond = (regA == regB);
         4'hD:    cond = (regA != regB);
         4'hE:    cond = (regA > regB);
         4'hF:    cond = ((regA & regB) != 16'h0000);
         default: cond = 1'b0;
      endcase
   end

   // Writeback to register-direct targets and PC writes (basic SET PC or JSR)
   always_comb begin
      rwe = CC && basic && (a_fld <= 6'h07);
      bra = CC && ((basic && (a_fld == 6'h1C)) || ((opc == 4'h0) && (a_fld == 6'h01)));
   end

   // Phase counter, instruction load and skip flag; a skipped IF is never
   // evaluated, so CC cannot stay low for more than one instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pha  <= 2'd0;
         ireg <= 16'h0000;
         CC   <= 1'b1;
      end else if (ena) begin
         pha <= pha + 2'd1;
         if (pha == 2'd2) begin
            ireg <= f_dti;
            CC   <= !(ifx && CC && !cond);
         end
      end
   end

endmodule

// File: tb/tb_dcpu16_ictl.sv
// Self-checking bench for dcpu16_ictl: reference model feeds a scoreboard
// queue, plus directed checks of the key scenarios.
module tb_dcpu16_ictl;

   logic        clk;
   logic        rst;
   logic        ena;
   logic [15:0] f_dti;
   logic [15:0] regA;
   logic [15:0] regB;
   logic [1:0]  pha;
   logic [15:0] ireg;
   logic [3:0]  opc;
   logic        CC;
   logic        bra;
   logic        rwe;
   logic        ifx;

   dcpu16_ictl dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .f_dti (f_dti),
      .regA  (regA),
      .regB  (regB),
      .pha   (pha),
      .ireg  (ireg),
      .opc   (opc),
      .CC    (CC),
      .bra   (bra),
      .rwe   (rwe),
      .ifx   (ifx)
   );

   typedef struct {
      logic [1:0]  pha;
      logic [15:0] ireg;
      logic        cc;
      logic        rwe;
      logic        bra;
      logic        ifx;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0]  m_pha;
   logic [15:0] m_ireg;
   logic        m_cc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, got timeout, wanted finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_cond(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
      case (op)
         4'hC:    return a == b;
         4'hD:    return a != b;
         4'hE:    return a > b;
         4'hF:    return (a & b) != 16'h0000;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t m_out();
      exp_t x;
      logic [3:0] op;
      logic       is_basic;
      op         = m_ireg[3:0];
      is_basic   = (op >= 4'h1) && (op <= 4'hB);
      x.pha      = m_pha;
      x.ireg     = m_ireg;
      x.cc       = m_cc;
      x.ifx      = (op >= 4'hC);
      x.rwe      = m_cc && is_basic && (m_ireg[9:7] == 3'b000);
      x.bra      = m_cc && ((is_basic && m_ireg[9:4] == 6'h1C) ||
                            (op == 4'h0 && m_ireg[9:4] == 6'h01));
      return x;
   endfunction

   // One clock: drive, predict, push; then sample after the edge and pop.
   task automatic step(input logic e, input logic r, input logic [15:0] d,
                       input logic [15:0] a, input logic [15:0] b);
      exp_t x;
      ena   = e;
      rst   = r;
      f_dti = d;
      regA  = a;
      regB  = b;
      if (r) begin
         m_pha  = 2'd0;
         m_ireg = 16'h0000;
         m_cc   = 1'b1;
      end else if (e) begin
         if (m_pha == 2'd2) begin
            m_cc   = !((m_ireg[3:0] >= 4'hC) && m_cc && !m_cond(m_ireg[3:0], a, b));
            m_ireg = d;
         end
         m_pha = m_pha + 2'd1;
      end
      sb.push_back(m_out());
      @(posedge clk);
      #1;
      x = sb.pop_front();
      cmp("sb_pha", {14'b0, pha}, {14'b0, x.pha});
      cmp("sb_ireg", ireg, x.ireg);
      cmp("sb_opc", {12'b0, opc}, {12'b0, x.ireg[3:0]});
      cmp("sb_cc", {15'b0, CC}, {15'b0, x.cc});
      cmp("sb_rwe", {15'b0, rwe}, {15'b0, x.rwe});
      cmp("sb_bra", {15'b0, bra}, {15'b0, x.bra});
      cmp("sb_ifx", {15'b0, ifx}, {15'b0, x.ifx});
   endtask

   // Run ena=1 edges until the pha==2 edge loads d; regA/regB held throughout.
   task automatic load(input logic [15:0] d, input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      while (m_pha != 2'd2 && n < 4) begin
         step(1'b1, 1'b0, 16'($urandom), a, b);
         n++;
      end
      step(1'b1, 1'b0, d, a, b);
      cmp("load_ireg", ireg, d);
   endtask

   initial begin
      m_pha  = 2'd0;
      m_ireg = 16'h0000;
      m_cc   = 1'b1;

      // Reset, with ena low and then high
      step(1'b0, 1'b1, 16'hFFFF, 16'h0, 16'h0);
      step(1'b1, 1'b1, 16'hFFFF, 16'h0, 16'h0);
      cmp("rst_pha", {14'b0, pha}, 16'd0);
      cmp("rst_ireg", ireg, 16'h0000);
      cmp("rst_cc", {15'b0, CC}, 16'd1);

      // First instruction: SET A, 0x1F-literal on the third edge
      step(1'b1, 1'b0, 16'h1111, 16'h0, 16'h0);
      cmp("seq_pha1", {14'b0, pha}, 16'd1);
      step(1'b1, 1'b0, 16'h2222, 16'h0, 16'h0);
      cmp("seq_pha2", {14'b0, pha}, 16'd2);
      cmp("seq_noload", ireg, 16'h0000);
      step(1'b1, 1'b0, 16'h7C01, 16'h0, 16'h0);
      cmp("seq_pha3", {14'b0, pha}, 16'd3);
      cmp("seq_ireg", ireg, 16'h7C01);
      cmp("seq_opc", {12'b0, opc}, 16'h1);
      cmp("seq_rwe", {15'b0, rwe}, 16'd1);
      cmp("seq_bra", {15'b0, bra}, 16'd0);
      step(1'b1, 1'b0, 16'h3333, 16'h0, 16'h0);
      cmp("seq_pha0", {14'b0, pha}, 16'd0);

      // IFE true: next instruction executes
      load(16'h040C, 16'h0, 16'h0);
      cmp("ife_ifx", {15'b0, ifx}, 16'd1);
      load(16'h0401, 16'h0005, 16'h0005);
      cmp("ife_cc", {15'b0, CC}, 16'd1);
      cmp("ife_rwe", {15'b0, rwe}, 16'd1);

      // IFN false: next instruction skipped, then CC recovers
      load(16'h040D, 16'h0, 16'h0);
      load(16'h0401, 16'h1234, 16'h1234);
      cmp("ifn_cc", {15'b0, CC}, 16'd0);
      cmp("ifn_rwe", {15'b0, rwe}, 16'd0);
      cmp("ifn_bra", {15'b0, bra}, 16'd0);
      load(16'h7C01, 16'h0, 16'h0);
      cmp("ifn_cc_back", {15'b0, CC}, 16'd1);

      // IFG is unsigned
      load(16'h040E, 16'h0, 16'h0);
      load(16'h0401, 16'h8000, 16'h7FFF);
      cmp("ifg_true_cc", {15'b0, CC}, 16'd1);
      load(16'h040E, 16'h0, 16'h0);
      load(16'h0401, 16'h7FFF, 16'h8000);
      cmp("ifg_false_cc", {15'b0, CC}, 16'd0);

      // Skipped IFB is not evaluated; SET PC that follows executes
      load(16'h040D, 16'h0, 16'h0);
      cmp("ifb_pre_cc", {15'b0, CC}, 16'd1);
      load(16'h040F, 16'h1234, 16'h1234);
      cmp("ifb_skip_cc", {15'b0, CC}, 16'd0);
      cmp("ifb_skip_ifx", {15'b0, ifx}, 16'd1);
      load(16'h7DC1, 16'h00F0, 16'h000F);
      cmp("setpc_cc", {15'b0, CC}, 16'd1);
      cmp("setpc_bra", {15'b0, bra}, 16'd1);
      cmp("setpc_rwe", {15'b0, rwe}, 16'd0);

      // Stall at pha 2 with f_dti changing
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom), 16'h0, 16'h0);
      cmp("stall_pre_pha", {14'b0, pha}, 16'd2);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
         cmp("stall_pha", {14'b0, pha}, 16'd2);
         cmp("stall_ireg", ireg, 16'h7DC1);
         cmp("stall_cc", {15'b0, CC}, 16'd1);
      end

      // JSR and a non-basic NOP
      step(1'b1, 1'b0, 16'h7C10, 16'h0, 16'h0);
      cmp("jsr_bra", {15'b0, bra}, 16'd1);
      cmp("jsr_rwe", {15'b0, rwe}, 16'd0);
      load(16'h0020, 16'h0, 16'h0);
      cmp("nop_bra", {15'b0, bra}, 16'd0);
      cmp("nop_rwe", {15'b0, rwe}, 16'd0);
      cmp("nop_ifx", {15'b0, ifx}, 16'd0);

      // Skip frozen by stall, then abandoned by reset mid-skip
      load(16'h040D, 16'h0, 16'h0);
      load(16'h0402, 16'h4321, 16'h4321);
      step(1'b0, 1'b0, 16'hAAAA, 16'h0, 16'h0);
      step(1'b0, 1'b0, 16'h5555, 16'h0, 16'h0);
      cmp("skip_stall_cc", {15'b0, CC}, 16'd0);
      step(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
      step(1'b1, 1'b1, 16'hBEEF, 16'h0, 16'h0);
      cmp("midrst_cc", {15'b0, CC}, 16'd1);
      cmp("midrst_pha", {14'b0, pha}, 16'd0);
      cmp("midrst_ireg", ireg, 16'h0000);
      load(16'h0401, 16'h0, 16'h0);
      cmp("postrst_cc", {15'b0, CC}, 16'd1);
      cmp("postrst_rwe", {15'b0, rwe}, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
